// File: rtl/hermes_tx_stage.sv
// hermes_tx_stage: registered output stage from the DMNI Hermes transmit port
// to the router local input port. A 2-entry credit-based buffer decouples the
// two sides. A framing tracker follows header/size/payload on the forwarded
// flits to report busy and end-of-packet.
// Optional injection counters are enabled by defining HERMES_TX_STATS_EN.
// Without it, the counters read 0 and stats_clear_i is ignored.
module hermes_tx_stage #(
   parameter int HERMES_FLIT_SIZE = 32
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        up_tx_i,
   output logic                        up_credit_o,
   input  logic [HERMES_FLIT_SIZE-1:0] up_data_i,
   output logic                        noc_tx_o,
   input  logic                        noc_credit_i,
   output logic [HERMES_FLIT_SIZE-1:0] noc_data_o,
   output logic                        busy_o,
   output logic                        eop_o,
   input  logic                        stats_clear_i,
   output logic [31:0]                 pkt_count_o,
   output logic [31:0]                 flit_count_o
);

   typedef enum logic [1:0] {
      ST_HEADER,
      ST_SIZE,
      ST_PAYLOAD
   } frame_state_t;

   logic [HERMES_FLIT_SIZE-1:0] buf_mem [2];
   logic                        rd_ptr;
   logic                        wr_ptr;
   logic [1:0]                  count;
   frame_state_t                state;
   logic [HERMES_FLIT_SIZE-1:0] remaining;
   logic                        push;
   logic                        pop;
   logic                        last_flit;

   assign up_credit_o = (count != 2'd2);
   assign noc_tx_o    = (count != 2'd0);
   assign noc_data_o  = buf_mem[rd_ptr];
   assign push        = up_tx_i && up_credit_o;
   assign pop         = noc_tx_o && noc_credit_i;
   assign busy_o      = (state != ST_HEADER);

   // The size flit itself closes a zero-length packet; otherwise the payload
   // flit seen while one payload flit is left closes it.
   assign last_flit = ((state == ST_SIZE) && (noc_data_o == '0)) ||
                      ((state == ST_PAYLOAD) && (remaining == HERMES_FLIT_SIZE'(1)));
   assign eop_o     = pop && last_flit;

   // Two-entry ring buffer; a simultaneous push and pop leaves the occupancy unchanged.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         count      <= 2'd0;
      end else begin
         if (push) begin
            buf_mem[wr_ptr] <= up_data_i;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         if (push && !pop) begin
            count <= count + 2'd1;
         end else if (pop && !push) begin
            count <= count - 2'd1;
         end
      end
   end

   // Framing tracker advances only when a flit actually leaves toward the router.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= ST_HEADER;
         remaining <= '0;
      end else if (pop) begin
         case (state)
            ST_HEADER: begin
               state <= ST_SIZE;
            end
            ST_SIZE: begin
               remaining <= noc_data_o;
               state     <= (noc_data_o == '0) ? ST_HEADER : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
               remaining <= remaining - HERMES_FLIT_SIZE'(1);
               if (remaining == HERMES_FLIT_SIZE'(1)) begin
                  state <= ST_HEADER;
               end
            end
            default: begin
               state <= ST_HEADER;
            end
         endcase
      end
   end

`ifdef HERMES_TX_STATS_EN
   logic [31:0] pkt_count_q;
   logic [31:0] flit_count_q;

   // Injection counters; a clear in the same cycle as an increment wins.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pkt_count_q  <= 32'd0;
         flit_count_q <= 32'd0;
      end else if (stats_clear_i) begin
         pkt_count_q  <= 32'd0;
         flit_count_q <= 32'd0;
      end else begin
         if (pop) begin
            flit_count_q <= flit_count_q + 32'd1;
         end
         if (eop_o) begin
            pkt_count_q <= pkt_count_q + 32'd1;
         end
      end
   end

   assign pkt_count_o  = pkt_count_q;
   assign flit_count_o = flit_count_q;
`else
   logic unused_stats_clear;

   assign unused_stats_clear = stats_clear_i;
   assign pkt_count_o        = 32'd0;
   assign flit_count_o       = 32'd0;
`endif

endmodule

// File: tb/tb_hermes_tx_stage.sv
// tb_hermes_tx_stage: self-checking bench for hermes_tx_stage. A queue-based
// reference model predicts the buffer contents, packet position and counters.
// Directed scenarios and a randomized traffic run are compared against it.
module tb_hermes_tx_stage;

   localparam int W = 32;
`ifdef HERMES_TX_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          up_tx_i;
   logic          up_credit_o;
   logic [W-1:0]  up_data_i;
   logic          noc_tx_o;
   logic          noc_credit_i;
   logic [W-1:0]  noc_data_o;
   logic          busy_o;
   logic          eop_o;
   logic          stats_clear_i;
   logic [31:0]   pkt_count_o;
   logic [31:0]   flit_count_o;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [W-1:0]  mq[$];
   longint        pkt_pos;
   longint        pkt_len;
   logic [31:0]   m_pkts;
   logic [31:0]   m_flits;
   logic          e_credit, e_tx, e_busy, e_eop, m_push, m_pop;
   logic [W-1:0]  e_data;

   always #5 clk_i = ~clk_i;

   hermes_tx_stage #(.HERMES_FLIT_SIZE(W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .up_tx_i(up_tx_i), .up_credit_o(up_credit_o), .up_data_i(up_data_i),
      .noc_tx_o(noc_tx_o), .noc_credit_i(noc_credit_i), .noc_data_o(noc_data_o),
      .busy_o(busy_o), .eop_o(eop_o), .stats_clear_i(stats_clear_i),
      .pkt_count_o(pkt_count_o), .flit_count_o(flit_count_o)
   );

   function automatic void model_reset();
      mq.delete();
      pkt_pos = 0;
      pkt_len = 0;
      m_pkts  = 0;
      m_flits = 0;
   endfunction

   // packet position: 0 = header next, 1 = size next, k>=2 = (k-1)-th payload next
   function automatic void predict();
      e_credit = (mq.size() < 2);
      e_tx     = (mq.size() > 0);
      e_data   = e_tx ? mq[0] : '0;
      e_busy   = (pkt_pos != 0);
      m_pop    = e_tx && noc_credit_i;
      m_push   = up_tx_i && e_credit;
      e_eop    = 1'b0;
      if (m_pop) begin
         if (pkt_pos == 1 && mq[0] == '0) e_eop = 1'b1;
         if (pkt_pos >= 2 && pkt_pos == pkt_len - 1) e_eop = 1'b1;
      end
   endfunction

   function automatic void model_edge();
      logic [W-1:0] head;
      if (m_pop) begin
         head = mq.pop_front();
         if (pkt_pos == 0) pkt_pos = 1;
         else if (pkt_pos == 1) begin
            if (head == '0) pkt_pos = 0;
            else begin
               pkt_len = longint'(head) + 2;
               pkt_pos = 2;
            end
         end else if (pkt_pos == pkt_len - 1) pkt_pos = 0;
         else pkt_pos = pkt_pos + 1;
      end
      if (m_push) mq.push_back(up_data_i);
      if (STATS) begin
         if (stats_clear_i) begin
            m_pkts  = 0;
            m_flits = 0;
         end else begin
            if (m_pop) m_flits = m_flits + 1;
            if (e_eop) m_pkts = m_pkts + 1;
         end
      end
   endfunction

   task automatic applyStimulus(input logic tx, input logic [W-1:0] data, input logic credit, input logic clear);
      up_tx_i       = tx;
      up_data_i     = data;
      noc_credit_i  = credit;
      stats_clear_i = clear;
      #1;
      predict();
   endtask

   task automatic step();
      @(posedge clk_i);
      model_edge();
      @(negedge clk_i);
   endtask

   task automatic apply_reset();
      rst_ni = 1'b0;
      up_tx_i = 1'b0;
      noc_credit_i = 1'b0;
      stats_clear_i = 1'b0;
      up_data_i = '0;
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      n_checks += 7;
      if (up_credit_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_credit got=%0b exp=1", up_credit_o); end
      if (noc_tx_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_tx got=%0b exp=0", noc_tx_o); end
      if (noc_data_o !== '0) begin n_fail++; $display("[TB] FAIL rst_data got=%0h exp=0", noc_data_o); end
      if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy got=%0b exp=0", busy_o); end
      if (eop_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_eop got=%0b exp=0", eop_o); end
      if (pkt_count_o !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_pkt got=%0d exp=0", pkt_count_o); end
      if (flit_count_o !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_flit got=%0d exp=0", flit_count_o); end
      @(negedge clk_i);
      rst_ni = 1'b1;
      model_reset();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] f[7] = '{32'h0000_0102, 32'd3, 32'hA, 32'hB, 32'hC, 32'h0, 32'h0};
      for (int c = 0; c < 7; c++) begin
         applyStimulus(c < 5, f[c], 1'b1, 1'b0);
         n_checks += 4;
         if (noc_tx_o !== e_tx) begin n_fail++; $display("[TB] FAIL b2b_tx c=%0d got=%0b exp=%0b", c, noc_tx_o, e_tx); end
         if (eop_o !== (c == 5)) begin n_fail++; $display("[TB] FAIL b2b_eop c=%0d got=%0b exp=%0b", c, eop_o, c == 5); end
         if (busy_o !== (c >= 2 && c <= 5)) begin n_fail++; $display("[TB] FAIL b2b_busy c=%0d got=%0b exp=%0b", c, busy_o, (c >= 2 && c <= 5)); end
         if (busy_o !== e_busy) begin n_fail++; $display("[TB] FAIL b2b_busy_model c=%0d got=%0b exp=%0b", c, busy_o, e_busy); end
         if (c >= 1 && c <= 5) begin
            n_checks++;
            if (noc_tx_o !== 1'b1 || noc_data_o !== f[c-1]) begin
               n_fail++; $display("[TB] FAIL b2b_latency c=%0d got=%0h exp=%0h", c, noc_data_o, f[c-1]);
            end
         end
         step();
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      n_checks += 2;
      if (pkt_count_o !== (STATS ? 32'd1 : 32'd0)) begin n_fail++; $display("[TB] FAIL b2b_pkt got=%0d exp=%0d", pkt_count_o, STATS ? 1 : 0); end
      if (flit_count_o !== (STATS ? 32'd5 : 32'd0)) begin n_fail++; $display("[TB] FAIL b2b_flit got=%0d exp=%0d", flit_count_o, STATS ? 5 : 0); end
   endtask

   task automatic test_zero_size();
      logic [W-1:0] f[7] = '{32'h55, 32'd0, 32'h77, 32'd1, 32'h99, 32'h0, 32'h0};
      for (int c = 0; c < 7; c++) begin
         applyStimulus(c < 5, f[c], 1'b1, 1'b0);
         n_checks += 3;
         if (eop_o !== (c == 2 || c == 5)) begin n_fail++; $display("[TB] FAIL zero_eop c=%0d got=%0b exp=%0b", c, eop_o, (c == 2 || c == 5)); end
         if (busy_o !== e_busy) begin n_fail++; $display("[TB] FAIL zero_busy c=%0d got=%0b exp=%0b", c, busy_o, e_busy); end
         if (e_tx && noc_data_o !== e_data) begin n_fail++; $display("[TB] FAIL zero_data c=%0d got=%0h exp=%0h", c, noc_data_o, e_data); end
         step();
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      n_checks += 2;
      if (pkt_count_o !== (STATS ? 32'd3 : 32'd0)) begin n_fail++; $display("[TB] FAIL zero_pkt got=%0d exp=%0d", pkt_count_o, STATS ? 3 : 0); end
      if (flit_count_o !== (STATS ? 32'd10 : 32'd0)) begin n_fail++; $display("[TB] FAIL zero_flit got=%0d exp=%0d", flit_count_o, STATS ? 10 : 0); end
   endtask

   task automatic test_back_pressure();
      logic [W-1:0] src[4];
      logic [W-1:0] got[$];
      int idx = 0;
      src[0] = 32'h0000_0200;
      src[1] = 32'd2;
      src[2] = $urandom;
      src[3] = $urandom;
      for (int c = 0; c < 5; c++) begin
         applyStimulus(idx < 4, src[idx < 4 ? idx : 0], 1'b0, 1'b0);
         n_checks += 2;
         if (up_credit_o !== (c < 2)) begin n_fail++; $display("[TB] FAIL bp_credit c=%0d got=%0b exp=%0b", c, up_credit_o, c < 2); end
         if (noc_tx_o !== (c >= 1)) begin n_fail++; $display("[TB] FAIL bp_tx c=%0d got=%0b exp=%0b", c, noc_tx_o, c >= 1); end
         step();
         if (m_push) idx++;
      end
      n_checks++;
      if (idx != 2) begin n_fail++; $display("[TB] FAIL bp_buffered got=%0d exp=2", idx); end
      for (int c = 0; c < 12 && !(got.size() == 4 && idx == 4); c++) begin
         applyStimulus(idx < 4, src[idx < 4 ? idx : 0], 1'b1, 1'b0);
         n_checks++;
         if (up_credit_o !== e_credit) begin n_fail++; $display("[TB] FAIL bp_credit_ret c=%0d got=%0b exp=%0b", c, up_credit_o, e_credit); end
         if (noc_tx_o === 1'b1) got.push_back(noc_data_o);
         step();
         if (m_push) idx++;
      end
      n_checks++;
      if (got.size() != 4) begin n_fail++; $display("[TB] FAIL bp_count got=%0d exp=4", got.size()); end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         n_checks++;
         if (got[i] !== src[i]) begin n_fail++; $display("[TB] FAIL bp_order i=%0d got=%0h exp=%0h", i, got[i], src[i]); end
      end
   endtask

   task automatic test_simul_push_pop();
      logic [W-1:0] v[11];
      for (int i = 0; i < 11; i++) v[i] = $urandom;
      applyStimulus(1'b1, v[0], 1'b0, 1'b0);
      step();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, v[i+1], 1'b1, 1'b0);
         n_checks += 3;
         if (noc_tx_o !== 1'b1) begin n_fail++; $display("[TB] FAIL simul_tx i=%0d got=%0b exp=1", i, noc_tx_o); end
         if (up_credit_o !== 1'b1) begin n_fail++; $display("[TB] FAIL simul_credit i=%0d got=%0b exp=1", i, up_credit_o); end
         if (noc_data_o !== v[i]) begin n_fail++; $display("[TB] FAIL simul_data i=%0d got=%0h exp=%0h", i, noc_data_o, v[i]); end
         step();
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      step();
   endtask

   task automatic test_mid_reset();
      logic [W-1:0] f[5] = '{32'h0000_0500, 32'd5, 32'h11, 32'h22, 32'h33};
      logic [W-1:0] g[6] = '{32'h0000_0300, 32'd1, 32'hDD, 32'h0, 32'h0, 32'h0};
      apply_reset();
      for (int c = 0; c < 5; c++) begin
         applyStimulus(c < 4, f[c < 4 ? c : 0], 1'b1, 1'b0);
         step();
      end
      applyStimulus(1'b1, f[4], 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      n_checks += 2;
      if (busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_busy_pre got=%0b exp=1", busy_o); end
      if (noc_tx_o !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_tx_pre got=%0b exp=1", noc_tx_o); end
      rst_ni = 1'b0;
      #1;
      n_checks += 7;
      if (up_credit_o !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_credit got=%0b exp=1", up_credit_o); end
      if (noc_tx_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_tx got=%0b exp=0", noc_tx_o); end
      if (noc_data_o !== '0) begin n_fail++; $display("[TB] FAIL midrst_data got=%0h exp=0", noc_data_o); end
      if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy got=%0b exp=0", busy_o); end
      if (eop_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_eop got=%0b exp=0", eop_o); end
      if (pkt_count_o !== 32'd0) begin n_fail++; $display("[TB] FAIL midrst_pkt got=%0d exp=0", pkt_count_o); end
      if (flit_count_o !== 32'd0) begin n_fail++; $display("[TB] FAIL midrst_flit got=%0d exp=0", flit_count_o); end
      model_reset();
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int c = 0; c < 5; c++) begin
         applyStimulus(c < 3, g[c], 1'b1, 1'b0);
         n_checks += 3;
         if (eop_o !== (c == 3)) begin n_fail++; $display("[TB] FAIL midrst_new_eop c=%0d got=%0b exp=%0b", c, eop_o, c == 3); end
         if (busy_o !== e_busy) begin n_fail++; $display("[TB] FAIL midrst_new_busy c=%0d got=%0b exp=%0b", c, busy_o, e_busy); end
         if (e_tx && noc_data_o !== e_data) begin n_fail++; $display("[TB] FAIL midrst_new_data c=%0d got=%0h exp=%0h", c, noc_data_o, e_data); end
         step();
      end
   endtask

   task automatic test_stats_clear();
      logic [W-1:0] f[4] = '{32'h0000_0400, 32'd0, 32'h0, 32'h0};
      bit saw_eop = 1'b0;
      for (int c = 0; c < 4; c++) begin
         applyStimulus(c < 2, f[c], 1'b1, 1'b0);
         if (e_eop) begin
            saw_eop = 1'b1;
            stats_clear_i = 1'b1;
            #1;
            predict();
         end
         step();
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      n_checks += 3;
      if (!saw_eop) begin n_fail++; $display("[TB] FAIL stats_eop_seen got=0 exp=1"); end
      if (pkt_count_o !== 32'd0) begin n_fail++; $display("[TB] FAIL stats_clear_pkt got=%0d exp=0", pkt_count_o); end
      if (flit_count_o !== 32'd0) begin n_fail++; $display("[TB] FAIL stats_clear_flit got=%0d exp=0", flit_count_o); end
   endtask

   task automatic test_random();
      logic [W-1:0] src[$];
      logic         holding = 1'b0;
      logic         tx;
      int           cyc = 0;
      int           sz;
      apply_reset();
      for (int p = 0; p < 40; p++) begin
         src.push_back($urandom);
         sz = $urandom_range(0, 3);
         src.push_back(W'(sz));
         for (int k = 0; k < sz; k++) src.push_back($urandom);
      end
      while ((src.size() > 0 || mq.size() > 0) && cyc < 3000) begin
         if (holding) tx = 1'b1;
         else tx = (src.size() > 0) && ($urandom_range(0, 3) != 0);
         applyStimulus(tx, tx ? src[0] : '0, $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
         n_checks += 7;
         if (up_credit_o !== e_credit) begin n_fail++; $display("[TB] FAIL rnd_credit cyc=%0d got=%0b exp=%0b", cyc, up_credit_o, e_credit); end
         if (noc_tx_o !== e_tx) begin n_fail++; $display("[TB] FAIL rnd_tx cyc=%0d got=%0b exp=%0b", cyc, noc_tx_o, e_tx); end
         if (e_tx && noc_data_o !== e_data) begin n_fail++; $display("[TB] FAIL rnd_data cyc=%0d got=%0h exp=%0h", cyc, noc_data_o, e_data); end
         if (busy_o !== e_busy) begin n_fail++; $display("[TB] FAIL rnd_busy cyc=%0d got=%0b exp=%0b", cyc, busy_o, e_busy); end
         if (eop_o !== e_eop) begin n_fail++; $display("[TB] FAIL rnd_eop cyc=%0d got=%0b exp=%0b", cyc, eop_o, e_eop); end
         if (pkt_count_o !== m_pkts) begin n_fail++; $display("[TB] FAIL rnd_pkt cyc=%0d got=%0d exp=%0d", cyc, pkt_count_o, m_pkts); end
         if (flit_count_o !== m_flits) begin n_fail++; $display("[TB] FAIL rnd_flit cyc=%0d got=%0d exp=%0d", cyc, flit_count_o, m_flits); end
         step();
         if (m_push) begin
            void'(src.pop_front());
            holding = 1'b0;
         end else begin
            holding = tx;
         end
         cyc++;
      end
      n_checks++;
      if (src.size() > 0 || mq.size() > 0) begin
         n_fail++; $display("[TB] FAIL rnd_timeout got=%0d_left exp=0_left", src.size() + mq.size());
      end
   endtask

   // Hard stop in case a scenario stalls
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      up_tx_i = 1'b0;
      up_data_i = '0;
      noc_credit_i = 1'b0;
      stats_clear_i = 1'b0;
      rst_ni = 1'b0;
      model_reset();
      @(negedge clk_i);
      test_reset();
      test_back_to_back();
      test_zero_size();
      test_back_pressure();
      test_simul_push_pop();
      test_mid_reset();
      test_stats_clear();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hermes_tx_stage.md
# hermes_tx_stage

Registered output stage between the DMNI Hermes transmit port and the local input port of the Hermes router. It cuts the combinational path from DMNI to router with a 2-entry credit-based buffer. It tracks packet framing (header, size, payload) on the flits it forwards, and reports end-of-packet and busy status. Optional traffic counters provide per-PE NoC injection statistics.

## Interface
- HERMES_FLIT_SIZE, 32, flit width in bits; also the width of the size flit and of the payload counter.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- up_tx_i  in  1  DMNI flit valid (DMNI noc_tx_o).
- up_credit_o  out  1  stage can accept a flit (to DMNI noc_credit_i).
- up_data_i  in  HERMES_FLIT_SIZE  DMNI flit.
- noc_tx_o  out  1  flit valid toward router local port.
- noc_credit_i  in  1  router can accept a flit.
- noc_data_o  out  HERMES_FLIT_SIZE  flit toward router.
- busy_o  out  1  a packet is in flight through the stage; header has left, last flit has not.
- eop_o  out  1  final flit of a packet is transferring to the router this cycle.
- stats_clear_i  in  1  synchronous clear of the counters.
- pkt_count_o  out  32  packets completed (counter).
- flit_count_o  out  32  flits transferred to the router (counter).

## Operation
- Buffer: 2-entry FIFO with a count register (0..2).
  - Push = up_tx_i && up_credit_o.
  - Pop = noc_tx_o && noc_credit_i.
  - up_credit_o = (count != 2).
  - noc_tx_o = (count != 0).
  - noc_data_o = head entry.
  - Push and pop in the same cycle: count is unchanged and order is preserved.
  - up_tx_i while up_credit_o = 0: the flit is not taken; DMNI holds it.
- Framing FSM, advanced only on pop:
  - HEADER: pop moves to SIZE.
  - SIZE: the popped flit value S is latched as remaining.
    - S = 0: eop_o is asserted and the FSM moves to HEADER.
    - Otherwise the FSM moves to PAYLOAD.
  - PAYLOAD: each pop decrements remaining.
    - The pop with remaining = 1 asserts eop_o and moves to HEADER.
- busy_o = (state != HEADER).
- eop_o is combinational: pop && last flit as defined above.
- The payload counter is HERMES_FLIT_SIZE wide, unsigned. S up to 2^HERMES_FLIT_SIZE − 1 is legal.
- Counters (see Configuration):
  - flit_count_o increments on every pop.
  - pkt_count_o increments on every eop_o.
  - Both wrap modulo 2^32.
  - stats_clear_i in the same cycle as an increment: the result is 0 (clear wins).
- Reset (async assert, sync release) forces:
  - count = 0, FSM = HEADER, counters = 0.
  - Outputs: up_credit_o = 1, noc_tx_o = 0, noc_data_o = 0, busy_o = 0, eop_o = 0, pkt_count_o = 0, flit_count_o = 0.
  - Reset mid-packet discards buffered flits and the framing state; no partial-packet recovery is attempted.

## Timing
- Latency: a flit pushed in cycle N is presented on noc_tx_o/noc_data_o in cycle N+1. With noc_credit_i high it transfers in cycle N+1.
- Throughput: one flit per cycle sustained while noc_credit_i stays high.
- Back-pressure:
  - noc_credit_i low for k cycles: the stage absorbs at most 2 flits.
  - up_credit_o deasserts the cycle after the second unpopped push (count register reaches 2).
  - up_credit_o reasserts in the cycle after the first pop from full.
- up_credit_o, noc_tx_o, noc_data_o and busy_o are driven from registers only. eop_o is combinational from registers and noc_credit_i.
- Counters update on the clock edge ending the pop cycle; they are visible one cycle after eop_o.

## Configuration
- HERMES_TX_STATS_EN defined:
  - pkt_count_o and flit_count_o are implemented as described.
  - stats_clear_i is honoured.
- HERMES_TX_STATS_EN undefined:
  - No counter registers are synthesised.
  - pkt_count_o and flit_count_o are tied to 0; stats_clear_i is ignored.
  - All other behaviour is identical.

## Test plan
- Back-to-back packet: header 0x0000_0102, size 3, payloads 0xA,0xB,0xC with noc_credit_i=1.
  - Flits appear in order, each one cycle after push.
  - eop_o high only on 0xC.
  - busy_o high from the cycle after the header pop until the cycle after the 0xC pop.
  - pkt_count_o=1, flit_count_o=5.
- Back-pressure: noc_credit_i=0 for 5 cycles while DMNI offers 4 flits.
  - Exactly 2 flits are buffered and up_credit_o goes low.
  - On credit return all 4 flits emerge in order, none lost or duplicated.
- Zero-size packet: header, size 0.
  - eop_o on the size flit; FSM returns to HEADER.
  - The next flit is treated as a header; pkt_count_o increments by 1.
- Simultaneous push/pop at count 1 over 10 cycles: count stays 1 and data order is preserved.
- Mid-packet reset after 2 of 5 payload flits:
  - All outputs take their reset values immediately.
  - After release, a new 1-payload packet frames correctly, with eop_o on its payload flit.
- Stats: stats_clear_i asserted in the same cycle as an eop_o pop gives pkt_count_o=0 and flit_count_o=0. Without HERMES_TX_STATS_EN both counters read 0 throughout.
